// File: rtl/dot_scan_scheduler_pkg.sv
// rtl/dot_scan_scheduler_pkg.sv - shared constants and FSM encoding for the dot scan scheduler
package dot_scan_scheduler_pkg;

    localparam int DEF_MEM_LENGTH         = 48;
    localparam int DEF_MEM_ADDRESS_LENGTH = 6;
    localparam int DEF_TIMER_WIDTH        = 16;
    localparam int DEF_SETUP_CYCLES       = 4;
    localparam int DEF_MIN_PULSE          = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FIRE  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dot_phase_timer.sv
// rtl/dot_phase_timer.sv - loadable down-counter timing the setup, fire and dead phases
module dot_phase_timer #(
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] value,
    output logic                   expired
);

    logic [TIMER_WIDTH-1:0] count;

    // Loading L-1 makes a phase last exactly L cycles before expired is seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - TIMER_WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/dot_scan_scheduler.sv
// rtl/dot_scan_scheduler.sv - walks every dot of a flip-dot frame through setup, fire and dead phases
module dot_scan_scheduler
    import dot_scan_scheduler_pkg::*;
#(
    parameter int MEM_LENGTH         = DEF_MEM_LENGTH,
    parameter int MEM_ADDRESS_LENGTH = DEF_MEM_ADDRESS_LENGTH,
    parameter int TIMER_WIDTH        = DEF_TIMER_WIDTH,
    parameter int SETUP_CYCLES       = DEF_SETUP_CYCLES,
    parameter int MIN_PULSE          = DEF_MIN_PULSE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          scan_order,
    input  logic                          invert_mode,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_limit,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_limit,
    input  logic [TIMER_WIDTH-1:0]        pulse_cycles,
    input  logic [TIMER_WIDTH-1:0]        dead_cycles,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          row_col_select,
    output logic                          output_active,
    output logic                          inverter_select,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int MAL = MEM_ADDRESS_LENGTH;
    localparam int TW  = TIMER_WIDTH;
    localparam logic [MAL-1:0] LIMIT_MAX = MAL'(MEM_LENGTH - 1);

    state_t         state;
    logic [MAL-1:0] row_lim;
    logic [MAL-1:0] col_lim;
    logic [TW-1:0]  eff_pulse;
    logic [TW-1:0]  eff_dead;
    logic           invert_q;
    logic           aborting;

    logic           timer_load;
    logic [TW-1:0]  timer_value;
    logic           timer_expired;

    logic [MAL-1:0] row_clamp;
    logic [MAL-1:0] col_clamp;
    logic [TW-1:0]  pulse_eff_in;
    logic [TW-1:0]  dead_eff_in;
    logic           last_dot;
    logic           stop_req;

    assign row_clamp    = (row_limit > LIMIT_MAX) ? LIMIT_MAX : row_limit;
    assign col_clamp    = (col_limit > LIMIT_MAX) ? LIMIT_MAX : col_limit;
    assign pulse_eff_in = (pulse_cycles < TW'(MIN_PULSE)) ? TW'(MIN_PULSE) : pulse_cycles;
    assign dead_eff_in  = (dead_cycles == '0) ? TW'(1) : dead_cycles;
    assign last_dot     = (row_select == row_lim) && (col_select == col_lim);
    assign stop_req     = abort || aborting;

    dot_phase_timer #(
        .TIMER_WIDTH(TW)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // Timer reloads on exactly the edges where the FSM below changes phase.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    timer_load  = 1'b1;
                    timer_value = TW'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP, ST_FIRE: begin
                if (abort) begin
                    timer_load  = 1'b1;
                    timer_value = eff_dead - TW'(1);
                end else if (timer_expired) begin
                    timer_load  = 1'b1;
                    timer_value = (state == ST_SETUP) ? eff_pulse - TW'(1) : eff_dead - TW'(1);
                end
            end
            ST_DEAD: begin
                if (timer_expired && !stop_req && !last_dot) begin
                    timer_load  = 1'b1;
                    timer_value = TW'(SETUP_CYCLES - 1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            row_select      <= '0;
            col_select      <= '0;
            row_col_select  <= 1'b0;
            output_active   <= 1'b0;
            inverter_select <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            row_lim         <= '0;
            col_lim         <= '0;
            eff_pulse       <= '0;
            eff_dead        <= '0;
            invert_q        <= 1'b0;
            aborting        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        row_lim        <= row_clamp;
                        col_lim        <= col_clamp;
                        eff_pulse      <= pulse_eff_in;
                        eff_dead       <= dead_eff_in;
                        row_col_select <= scan_order;
                        invert_q       <= invert_mode;
                        aborting       <= 1'b0;
                        row_select     <= '0;
                        col_select     <= '0;
                        busy           <= 1'b1;
                        state          <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        aborting <= 1'b1;
                        state    <= ST_DEAD;
                    end else if (timer_expired) begin
                        output_active <= 1'b1;
                        state         <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    if (abort || timer_expired) begin
                        aborting      <= aborting | abort;
                        output_active <= 1'b0;
                        state         <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (abort) begin
                        aborting <= 1'b1;
                    end
                    if (timer_expired) begin
                        if (stop_req) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (last_dot) begin
                            frame_done <= 1'b1;
                            if (invert_q) begin
                                inverter_select <= ~inverter_select;
                            end
                            state <= ST_DONE;
                        end else begin
                            // Fast axis wraps at its limit and carries into the slow axis.
                            if (!row_col_select) begin
                                if (col_select == col_lim) begin
                                    col_select <= '0;
                                    row_select <= row_select + MAL'(1);
                                end else begin
                                    col_select <= col_select + MAL'(1);
                                end
                            end else begin
                                if (row_select == row_lim) begin
                                    row_select <= '0;
                                    col_select <= col_select + MAL'(1);
                                end else begin
                                    row_select <= row_select + MAL'(1);
                                end
                            end
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
